// File: rtl/alu_serial_32_if.sv
// Request/response bundle for the nibble-serial 32-bit ALU.
// The master drives operands and start; the slave returns status and registered results.
interface alu_serial_32_if;
  logic        start;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [2:0]  op;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        cout;
  logic        over;

  modport master (
    output start, src1, src2, op,
    input  busy, done, result, zero, cout, over
  );

  modport slave (
    input  start, src1, src2, op,
    output busy, done, result, zero, cout, over
  );
endinterface

// File: rtl/alu_serial_32.sv
// Nibble-serial 32-bit ALU: AND, OR, ADD, SUB and SLT, computed 4 bits per cycle
// over 8 cycles, with flags and result committed together when the last nibble lands.
module alu_serial_32 (
  input  logic            clk,
  input  logic            rst_n,
  alu_serial_32_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  state_t      state;
  logic [31:0] a_sh;
  logic [31:0] b_sh;
  logic [31:0] shadow;
  logic [2:0]  op_r;
  logic [2:0]  cnt;
  logic        carry;

  logic        is_sub;
  logic [3:0]  b_eff;
  logic [4:0]  sum5;
  logic [3:0]  nib;
  logic [31:0] full;
  logic        ovf;
  logic [31:0] fin_res;
  logic        fin_cout;
  logic        fin_over;

  // Operands shift right so the current nibble always sits in bits 3:0; results
  // shift in from the top, so after the 8th nibble the shadow holds the full word.
  always_comb begin
    is_sub   = (op_r == OP_SUB) || (op_r == OP_SLT);
    b_eff    = is_sub ? ~b_sh[3:0] : b_sh[3:0];
    sum5     = {1'b0, a_sh[3:0]} + {1'b0, b_eff} + {4'b0000, carry};
    nib      = 4'h0;
    case (op_r)
      OP_AND:                 nib = a_sh[3:0] & b_sh[3:0];
      OP_OR:                  nib = a_sh[3:0] | b_sh[3:0];
      OP_ADD, OP_SUB, OP_SLT: nib = sum5[3:0];
      default:                nib = 4'h0;
    endcase
    full     = {nib, shadow[31:4]};
    ovf      = (a_sh[3] == b_eff[3]) && (sum5[3] != a_sh[3]);
    fin_res  = full;
    fin_cout = 1'b0;
    fin_over = 1'b0;
    case (op_r)
      OP_AND, OP_OR: ;
      OP_ADD, OP_SUB: begin
        fin_cout = sum5[4];
        fin_over = ovf;
      end
      OP_SLT:  fin_res = {31'b0, sum5[3] ^ ovf};
      default: fin_res = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_sh       <= 32'h0;
      b_sh       <= 32'h0;
      shadow     <= 32'h0;
      op_r       <= 3'b000;
      cnt        <= 3'd0;
      carry      <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= 32'h0;
      bus.zero   <= 1'b0;
      bus.cout   <= 1'b0;
      bus.over   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_sh     <= bus.src1;
            b_sh     <= bus.src2;
            op_r     <= bus.op;
            cnt      <= 3'd0;
            carry    <= (bus.op == OP_SUB) || (bus.op == OP_SLT);
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 4;
          b_sh   <= b_sh >> 4;
          shadow <= full;
          carry  <= sum5[4];
          cnt    <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            bus.result <= fin_res;
            bus.zero   <= (fin_res == 32'h0);
            bus.cout   <= fin_cout;
            bus.over   <= fin_over;
            bus.done   <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_serial_32.md
ALU_SERIAL_32 -- requirements
Module: alu_serial_32

Interface
REQ-001 Parameters: none; datapath width fixed at 32 bits, processed as 8 nibbles of 4 bits.
REQ-002 clk  input  1  rising-edge clock; sole clock of the block.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request pulse; accepted only in IDLE.
REQ-005 src1  input  32  operand A; sampled on accepted start.
REQ-006 src2  input  32  operand B; sampled on accepted start.
REQ-007 op  input  3  operation: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; sampled on accepted start.
REQ-008 busy  output  1  high in RUN and DONE states.
REQ-009 done  output  1  one-cycle pulse; result and flags are valid from this cycle.
REQ-010 result  output  32  registered result.
REQ-011 zero  output  1  registered; 1 iff result == 0.
REQ-012 cout  output  1  registered carry out of bit 31.
REQ-013 over  output  1  registered signed overflow.

Function
REQ-014 FSM states: IDLE, RUN, DONE. Transitions: IDLE->RUN on start; RUN->DONE after the 8th nibble; DONE->IDLE unconditionally.
REQ-015 Accepted start (IDLE, start=1) captures src1, src2 and op into internal registers, clears the nibble counter to 0, and loads the carry register with 1 for SUB/SLT and 0 otherwise.
REQ-016 RUN: one nibble per cycle, LSB nibble first. The nibble counter runs 0..7, and nibble k (bits 4k+3:4k) is computed in RUN cycle k.
REQ-017 Nibble datapath: AND/OR are bitwise; ADD is A+B+carry; SUB/SLT are A+~B+carry. The carry register takes the nibble carry-out each cycle.
REQ-018 Nibble results accumulate in an internal shadow register. result, zero, cout and over update together, once, on the RUN->DONE transition.
REQ-019 ADD/SUB: cout = carry out of bit 31; over = (a31 == b'31) && (s31 != a31), where b' is B for ADD and ~B for SUB.
REQ-020 SLT: result = {31'b0, s31 ^ over_sub}; cout = 0; over = 0.
REQ-021 AND/OR: cout = 0; over = 0.
REQ-022 Unused op codes: result = 0, zero = 1, cout = 0, over = 0; timing is identical to valid ops.
REQ-023 Latency: start accepted at edge t -> RUN at edges t+1..t+8 -> done=1 in cycle t+9. Throughput is one operation per 10 cycles.
REQ-024 start while busy=1, including the DONE cycle, is ignored and has no effect on captured operands.
REQ-025 result and flags hold their values from DONE until the next DONE; operand changes while busy have no effect.
REQ-026 The carry register does not wrap between operations; it is reloaded on every accepted start.

Reset
REQ-027 With rst_n=0 at a rising edge: FSM -> IDLE; busy, done, result, zero, cout, over and all internal registers -> 0.
REQ-028 Reset during RUN or DONE aborts the operation. No done pulse follows, and outputs read 0 from the next cycle.
REQ-029 rst_n has priority over start on the same edge.

Verification
REQ-030 AND: src1=0xFFFF0000, src2=0x0F0F0F0F, start at t -> done at t+9, result=0x0F0F0000, zero=0, cout=0, over=0.
REQ-031 ADD: 0x7FFFFFFF + 0x00000001 -> result=0x80000000, over=1, cout=0, zero=0; and 0xFFFFFFFF + 0x00000001 -> result=0, zero=1, cout=1, over=0.
REQ-032 SUB: 5 - 5 -> result=0, zero=1, cout=1, over=0; SLT: 0xFFFFFFFF vs 0x00000001 -> result=1; SLT: 1 vs 0xFFFFFFFF -> result=0.
REQ-033 Busy protection: start with op=ADD, then start pulses with new operands at t+3 and t+9 -> single done at t+9 carrying the original-operand result; busy low at t+10.
REQ-034 Reset mid-op: start at t, rst_n=0 at t+4 -> busy=0 and result=0 from t+5, no done pulse; a new start after reset completes normally in 10 cycles.
REQ-035 Unused op 011: result=0, zero=1, done at t+9.
